// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button conditioning block.
// Defaults assume a 50 MHz system clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  // 20 ms debounce window and 1 s long-press threshold.
  localparam int KEY_DEB_CYCLES  = 1_000_000;
  localparam int KEY_LONG_CYCLES = 50_000_000;

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, saturating hold counter
// and registered level / press / release / long-press outputs.
module key_filter_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES  = KEY_DEB_CYCLES,
  parameter int LONG_CYCLES = KEY_LONG_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);

  logic sync_q1, sync_q2;
  logic key_sync;

  key_state_t    state, state_next;
  logic [DW-1:0] deb_cnt, deb_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          level_next, press_next, release_next, long_next;

  // Both stages reset to the released level so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
    end
  end

  assign key_sync = sync_q2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      key_level   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_next;
      deb_cnt     <= deb_next;
      hold_cnt    <= hold_next;
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
      key_long    <= long_next;
    end
  end

  // A level change on the completing edge takes priority over completion.
  always_comb begin
    state_next   = state;
    deb_next     = deb_cnt;
    hold_next    = hold_cnt;
    level_next   = key_level;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;

    case (state)
      IDLE: begin
        if (!key_sync) begin
          state_next = PRESS_DB;
          deb_next   = DW'(1);
        end
      end

      PRESS_DB: begin
        if (key_sync) begin
          state_next = IDLE;
          deb_next   = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_next = HELD;
          deb_next   = '0;
          hold_next  = '0;
          level_next = 1'b0;
          press_next = 1'b1;
        end else begin
          deb_next = deb_cnt + DW'(1);
        end
      end

      // Counter saturates at LONG_MAX, so the long pulse can only fire once.
      HELD: begin
        if (hold_cnt != LONG_MAX) begin
          hold_next = hold_cnt + HW'(1);
          if (hold_cnt == LONG_MAX - HW'(1)) begin
            long_next = 1'b1;
          end
        end
        if (key_sync) begin
          state_next = RELEASE_DB;
          deb_next   = DW'(1);
        end
      end

      RELEASE_DB: begin
        if (!key_sync) begin
          state_next = HELD;
          deb_next   = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_next   = IDLE;
          deb_next     = '0;
          level_next   = 1'b1;
          release_next = 1'b1;
        end else begin
          deb_next = deb_cnt + DW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        deb_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_filter.sv
// Debounce front end for the board push buttons: one independent
// key_filter_ch per active-low key input.
module key_filter
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int DEB_CYCLES  = KEY_DEB_CYCLES,
  parameter int LONG_CYCLES = KEY_LONG_CYCLES
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter with DEB_CYCLES=8, LONG_CYCLES=32.
// Expected events are queued with their edge number when stimulus is driven.
module tb_key_filter;

  localparam int NUM_KEYS   = 4;
  localparam int DEB        = 8;
  localparam int LONG       = 32;
  localparam int LAT        = DEB + 2;
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  typedef struct {
    int edge_no;
    int ch;
    int kind;
  } event_t;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;

  event_t              exp_q[$];
  logic [NUM_KEYS-1:0] exp_level;
  int                  cyc      = 0;
  int                  checks   = 0;
  int                  failures = 0;

  always #5 sys_clk = ~sys_clk;

  key_filter #(
    .NUM_KEYS   (NUM_KEYS),
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Keep the queue ordered by edge so the monitor only ever looks at the head.
  function automatic void push_event(input int edge_no, input int ch, input int kind);
    event_t ev;
    int     idx;
    ev.edge_no = edge_no;
    ev.ch      = ch;
    ev.kind    = kind;
    idx        = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].edge_no > edge_no) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, ev);
  endfunction

  task automatic applyStimulus(input logic [NUM_KEYS-1:0] mask, input logic value);
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (mask[i]) key[i] = value;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic reset_pulse();
    sys_rst_n = 1'b0;
    exp_q.delete();
    exp_level = '1;
    #1;
    checkOutput("async_level", 32'(key_level), 32'hF);
    checkOutput("async_pulses", 32'({key_press, key_release, key_long}), 32'h0);
    wait_cycles(3);
    sys_rst_n = 1'b1;
  endtask

  // Scoreboard monitor: pops every event due on this edge and compares all outputs.
  always @(posedge sys_clk) begin
    logic [NUM_KEYS-1:0] ep, er, el;
    event_t ev;
    cyc = cyc + 1;
    #1;
    ep = '0;
    er = '0;
    el = '0;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
      ev = exp_q.pop_front();
      case (ev.kind)
        EV_PRESS: begin
          ep[ev.ch]        = 1'b1;
          exp_level[ev.ch] = 1'b0;
        end
        EV_RELEASE: begin
          er[ev.ch]        = 1'b1;
          exp_level[ev.ch] = 1'b1;
        end
        default: el[ev.ch] = 1'b1;
      endcase
    end
    checkOutput("key_press", 32'(key_press), 32'(ep));
    checkOutput("key_release", 32'(key_release), 32'(er));
    checkOutput("key_long", 32'(key_long), 32'(el));
    checkOutput("key_level", 32'(key_level), 32'(exp_level));
  end

  initial begin
    int e, r, d;
    key       = '1;
    sys_rst_n = 1'b1;
    exp_level = '1;
    #2 sys_rst_n = 1'b0;

    // Reset with all keys released.
    wait_cycles(3);
    checkOutput("reset_level", 32'(key_level), 32'hF);
    checkOutput("reset_pulses", 32'({key_press, key_release, key_long}), 32'h0);
    sys_rst_n = 1'b1;
    wait_cycles(20);
    checkOutput("idle_level", 32'(key_level), 32'hF);

    // key[0] press and release, no long press.
    applyStimulus(4'b0001, 1'b0);
    e = cyc + 1;
    push_event(e + LAT, 0, EV_PRESS);
    wait_cycles(19);
    applyStimulus(4'b0001, 1'b1);
    r = cyc + 1;
    push_event(r + LAT, 0, EV_RELEASE);
    wait_cycles(20);

    // key[1] bouncing with short low bursts: nothing accepted.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0010, 1'b0);
      wait_cycles(3);
      applyStimulus(4'b0010, 1'b1);
      wait_cycles(2);
    end
    wait_cycles(20);

    // key[2] long press, then a 4-cycle high glitch that must be absorbed.
    applyStimulus(4'b0100, 1'b0);
    e = cyc + 1;
    push_event(e + LAT, 2, EV_PRESS);
    push_event(e + LAT + LONG, 2, EV_LONG);
    wait_cycles(45);
    applyStimulus(4'b0100, 1'b1);
    wait_cycles(4);
    applyStimulus(4'b0100, 1'b0);
    wait_cycles(11);
    applyStimulus(4'b0100, 1'b1);
    r = cyc + 1;
    push_event(r + LAT, 2, EV_RELEASE);
    wait_cycles(20);

    // key[3] and key[0] together.
    applyStimulus(4'b1001, 1'b0);
    e = cyc + 1;
    push_event(e + LAT, 0, EV_PRESS);
    push_event(e + LAT, 3, EV_PRESS);
    wait_cycles(15);
    applyStimulus(4'b1001, 1'b1);
    r = cyc + 1;
    push_event(r + LAT, 0, EV_RELEASE);
    push_event(r + LAT, 3, EV_RELEASE);
    wait_cycles(20);

    // Reset mid-PRESS_DB and mid-HELD with key[0] held low throughout.
    applyStimulus(4'b0001, 1'b0);
    wait_cycles(5);
    reset_pulse();
    d = cyc + 1;
    push_event(d + LAT, 0, EV_PRESS);
    wait_cycles(15);
    checkOutput("held_level", 32'(key_level), 32'hE);
    reset_pulse();
    d = cyc + 1;
    push_event(d + LAT, 0, EV_PRESS);
    wait_cycles(15);
    applyStimulus(4'b0001, 1'b1);
    r = cyc + 1;
    push_event(r + LAT, 0, EV_RELEASE);
    wait_cycles(20);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    checkOutput("final_level", 32'(key_level), 32'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
